rv32i_fetch_unit: RTL and testbench

// Instruction fetch front end of the ToastCore pipeline, directly upstream of decode.
// - Owns the PC and issues word requests to the instruction memory over a req/gnt/rvalid handshake.
// - Buffers returned instructions with their PCs in an in-order queue.
// - Presents instructions to decode over a valid/ready handshake.
// - On a branch/jump redirect, flushes the queue and discards responses still in flight.
//

---
 rtl/rv32i_fetch_unit.sv | 121 ++++++++++++
 tb/tb_rv32i_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word fetches over req/gnt/rvalid and
// queues returned instructions with their PCs for decode. Redirects flush and drop stale data.
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        fetch_misaligned
);

  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] pc_q, pc_d;
  cnt_t        out_q, out_d;
  cnt_t        drop_q, drop_d;
  cnt_t        cnt_q, cnt_d;
  ptr_t        wr_q, wr_d, rd_q, rd_d;
  ptr_t        aw_q, aw_d, ar_q, ar_d;
  logic        mis_q, mis_d;

  logic [31:0] inst_mem [FIFO_DEPTH];
  logic [31:0] ipc_mem  [FIFO_DEPTH];
  logic [31:0] apc_mem  [FIFO_DEPTH];

  logic pop, issue, resp, push;
  cnt_t used;

  assign id_valid         = (cnt_q != '0);
  assign id_inst          = id_valid ? inst_mem[rd_q] : NOP;
  assign id_pc            = id_valid ? ipc_mem[rd_q] : 32'h0;
  assign imem_addr        = {pc_q[31:2], 2'b00};
  assign fetch_misaligned = mis_q;

  always_comb begin
    pop      = id_valid & id_ready & ~redirect_valid;
    // A head pop this cycle frees its slot, which keeps one fetch per cycle at depth 2.
    used     = out_q + cnt_q - cnt_t'(pop);
    imem_req = Reset_n & ~redirect_valid & ~mis_q & (used < cnt_t'(FIFO_DEPTH));
    issue    = imem_req & imem_gnt;
    resp     = imem_rvalid & (out_q != '0);
    push     = resp & (drop_q == '0) & ~redirect_valid;
  end

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q + cnt_t'(issue) - cnt_t'(resp);
    drop_d = drop_q;
    cnt_d  = cnt_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    aw_d   = issue ? aw_q + ptr_t'(1) : aw_q;
    ar_d   = resp ? ar_q + ptr_t'(1) : ar_q;
    mis_d  = mis_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      // Everything still in flight is stale; a response landing now is already consumed.
      drop_d = out_q - cnt_t'(resp);
      cnt_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
      mis_d  = (redirect_pc[1:0] != 2'b00);
    end else begin
      if (issue) pc_d = pc_q + 32'd4;
      if (resp && (drop_q != '0)) drop_d = drop_q - cnt_t'(1);
      cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);
      if (push) wr_d = wr_q + ptr_t'(1);
      if (pop) rd_d = rd_q + ptr_t'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      aw_q   <= '0;
      ar_q   <= '0;
      mis_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      aw_q   <= aw_d;
      ar_q   <= ar_d;
      mis_q  <= mis_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the counters above.
  always_ff @(posedge Clk) begin
    if (issue) apc_mem[aw_q] <= pc_q;
    if (push) begin
      inst_mem[wr_q] <= imem_rdata;
      ipc_mem[wr_q]  <= apc_mem[ar_q];
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Bench for rv32i_fetch_unit: cycle table for the directed cases, a second instance for PC
// wrap, mid-run reset, and a randomized memory/decode phase checked against a PC+4 model.
module tb_rv32i_fetch_unit;

  logic        Clk, Reset_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready, id_valid, fetch_misaligned;
  logic [31:0] id_inst, id_pc;

  logic        req2, rv2, valid2, mis2;
  logic [31:0] addr2, rd2, inst2, pc2;

  rv32i_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  rv32i_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .Clk(Clk), .Reset_n(Reset_n),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
    .imem_rvalid(rv2), .imem_rdata(rd2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_ready(1'b1), .id_valid(valid2), .id_inst(inst2), .id_pc(pc2),
    .fetch_misaligned(mis2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } pend_t;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    int          lat;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
    logic        emis;
  } vec_t;

  pend_t       pend[$];
  vec_t        tbl[$];
  int          cyc, nvec, nmis, npop;
  logic        rst_n_v, rdy_v, redir_v, g2, exp_on;
  logic [31:0] rpc_v, a2, exp_pc;
  int          lat_v;
  bit          gnt_rand, lat_rand;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[13:2] ^ a[31:20], 5'd0, 3'b000, a[6:2], 7'h13};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s cyc=%0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic redir, input logic [31:0] rpc, input int lat,
                     input logic ereq, input logic [31:0] eaddr, input logic evalid,
                     input logic [31:0] epc, input logic emis);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.lat = lat; v.ereq = ereq; v.eaddr = eaddr;
    v.evalid = evalid; v.epc = epc; v.emis = emis;
    tbl.push_back(v);
  endtask

  // One clock: drive inputs just after the rising edge, sample at the falling edge.
  task automatic cycle();
    int r;
    @(posedge Clk);
    #1;
    Reset_n        = rst_n_v;
    id_ready       = rdy_v;
    redirect_valid = redir_v;
    redirect_pc    = rpc_v;
    imem_gnt       = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!rst_n_v) begin
      pend.delete();
      g2 = 1'b0;
    end
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (rst_n_v && (pend.size() != 0) && (pend[0].ready <= cyc)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = imem(pend[0].addr);
      pend.delete(0);
    end
    rv2 = rst_n_v & g2;
    rd2 = imem(a2);
    @(negedge Clk);
    if (imem_req && imem_gnt) begin
      r = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat_v);
      if ((pend.size() != 0) && (pend[pend.size()-1].ready > r)) r = pend[pend.size()-1].ready;
      pend.push_back('{addr: imem_addr, ready: r});
    end
    g2 = req2;
    a2 = addr2;
    cyc++;
  endtask

  initial begin
    Reset_n = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; rv2 = 1'b0; rd2 = 32'h0;
    g2 = 1'b0; a2 = 32'h0; nvec = 0; nmis = 0; npop = 0; cyc = 0;
    rst_n_v = 1'b0; rdy_v = 1'b0; redir_v = 1'b0; rpc_v = 32'h0; lat_v = 1;
    gnt_rand = 1'b0; lat_rand = 1'b0; exp_on = 1'b0; exp_pc = 32'h0;

    //  rdy redir rpc        lat req addr        valid pc          mis
    add(1, 0, 32'h0,   1, 1, 32'h000, 0, 32'h000, 0); // c0 first request
    add(1, 0, 32'h0,   1, 1, 32'h004, 0, 32'h000, 0);
    add(1, 0, 32'h0,   1, 1, 32'h008, 1, 32'h000, 0); // c2 first instruction
    add(1, 0, 32'h0,   1, 1, 32'h00C, 1, 32'h004, 0);
    add(1, 0, 32'h0,   1, 1, 32'h010, 1, 32'h008, 0);
    add(1, 0, 32'h0,   1, 1, 32'h014, 1, 32'h00C, 0);
    add(0, 0, 32'h0,   1, 0, 32'h000, 1, 32'h010, 0); // c6 decode stalls, credits used
    add(0, 0, 32'h0,   1, 0, 32'h000, 1, 32'h010, 0);
    add(0, 0, 32'h0,   1, 0, 32'h000, 1, 32'h010, 0);
    add(0, 0, 32'h0,   1, 0, 32'h000, 1, 32'h010, 0);
    add(0, 0, 32'h0,   1, 0, 32'h000, 1, 32'h010, 0);
    add(1, 0, 32'h0,   1, 1, 32'h018, 1, 32'h010, 0); // c11 release
    add(1, 0, 32'h0,   1, 1, 32'h01C, 1, 32'h014, 0);
    add(1, 0, 32'h0,   1, 1, 32'h020, 1, 32'h018, 0);
    add(1, 0, 32'h0,   1, 1, 32'h024, 1, 32'h01C, 0);
    add(1, 1, 32'h300, 1, 0, 32'h000, 1, 32'h020, 0); // c15 redirect, response same cycle
    add(1, 0, 32'h0,   1, 1, 32'h300, 0, 32'h000, 0);
    add(1, 0, 32'h0,   1, 1, 32'h304, 0, 32'h000, 0);
    add(1, 0, 32'h0,   1, 1, 32'h308, 1, 32'h300, 0); // 3-cycle penalty
    add(1, 0, 32'h0,   3, 1, 32'h30C, 1, 32'h304, 0);
    add(1, 0, 32'h0,   3, 1, 32'h310, 1, 32'h308, 0);
    add(1, 1, 32'h100, 1, 0, 32'h000, 0, 32'h000, 0); // c21 redirect, 2 outstanding
    add(1, 0, 32'h0,   1, 0, 32'h000, 0, 32'h000, 0);
    add(1, 0, 32'h0,   1, 1, 32'h100, 0, 32'h000, 0);
    add(1, 0, 32'h0,   1, 1, 32'h104, 0, 32'h000, 0);
    add(1, 0, 32'h0,   1, 1, 32'h108, 1, 32'h100, 0);
    add(1, 0, 32'h0,   1, 1, 32'h10C, 1, 32'h104, 0);
    add(1, 1, 32'h102, 1, 0, 32'h000, 1, 32'h108, 0); // c27 misaligned redirect
    add(1, 0, 32'h0,   1, 0, 32'h000, 0, 32'h000, 1);
    add(1, 0, 32'h0,   1, 0, 32'h000, 0, 32'h000, 1);
    add(1, 0, 32'h0,   1, 0, 32'h000, 0, 32'h000, 1);
    add(1, 1, 32'h200, 1, 0, 32'h000, 0, 32'h000, 1); // c31 aligned redirect recovers
    add(1, 0, 32'h0,   1, 1, 32'h200, 0, 32'h000, 0);
    add(1, 0, 32'h0,   1, 1, 32'h204, 0, 32'h000, 0);
    add(1, 0, 32'h0,   1, 1, 32'h208, 1, 32'h200, 0);
    add(1, 0, 32'h0,   1, 1, 32'h20C, 1, 32'h204, 0);

    repeat (3) cycle();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_inst", id_inst, 32'h0000_0013);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_mis", 32'(fetch_misaligned), 32'd0);

    rst_n_v = 1'b1;
    cyc = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      rdy_v = tbl[i].rdy; redir_v = tbl[i].redir; rpc_v = tbl[i].rpc; lat_v = tbl[i].lat;
      cycle();
      chk("tbl_req", 32'(imem_req), 32'(tbl[i].ereq));
      if (tbl[i].ereq) chk("tbl_addr", imem_addr, tbl[i].eaddr);
      chk("tbl_valid", 32'(id_valid), 32'(tbl[i].evalid));
      if (tbl[i].evalid) begin
        chk("tbl_pc", id_pc, tbl[i].epc);
        chk("tbl_inst", id_inst, imem(tbl[i].epc));
      end
      chk("tbl_mis", 32'(fetch_misaligned), 32'(tbl[i].emis));
      if (i >= 2 && i <= 4) begin
        chk("wrap_valid", 32'(valid2), 32'd1);
        chk("wrap_pc", pc2, 32'hFFFF_FFF8 + 32'(4 * (i - 2)));
        chk("wrap_inst", inst2, imem(32'hFFFF_FFF8 + 32'(4 * (i - 2))));
      end
    end

    // Sticky flag, then reset mid-operation clears everything.
    rdy_v = 1'b1; redir_v = 1'b1; rpc_v = 32'h3; lat_v = 1;
    cycle();
    redir_v = 1'b0;
    cycle();
    chk("mis_set", 32'(fetch_misaligned), 32'd1);
    chk("mis_noreq", 32'(imem_req), 32'd0);
    rst_n_v = 1'b0;
    cycle();
    chk("mrst_req", 32'(imem_req), 32'd0);
    chk("mrst_valid", 32'(id_valid), 32'd0);
    chk("mrst_inst", id_inst, 32'h0000_0013);
    chk("mrst_pc", id_pc, 32'h0);
    chk("mrst_mis", 32'(fetch_misaligned), 32'd0);
    rst_n_v = 1'b1;
    cyc = 0;
    cycle();
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    cycle();
    cycle();
    chk("rel_valid", 32'(id_valid), 32'd1);
    chk("rel_pc0", id_pc, 32'h0);
    cycle();
    chk("rel_pc1", id_pc, 32'h4);

    // Randomized handshakes against an in-order PC+4 model per redirect segment.
    gnt_rand = 1'b1; lat_rand = 1'b1;
    redir_v = 1'b1; rpc_v = 32'h1000;
    cycle();
    exp_pc = 32'h1000; exp_on = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      rdy_v   = ($urandom_range(0, 3) != 0);
      redir_v = ($urandom_range(0, fetch_misaligned ? 7 : 63) == 0);
      rpc_v   = $urandom() & 32'h0000_FFFC;
      if ($urandom_range(0, 7) == 0) rpc_v[1:0] = 2'b10;
      cycle();
      if (id_valid && id_ready && !redirect_valid) begin
        npop++;
        if (!exp_on) begin
          nvec++;
          nmis++;
          $display("FAIL sb_halted cyc=%0d: got pop of pc %h, want no pop", cyc, id_pc);
        end else begin
          chk("sb_pc", id_pc, exp_pc);
          chk("sb_inst", id_inst, imem(exp_pc));
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (fetch_misaligned) chk("sb_mis_req", 32'(imem_req), 32'd0);
      if (redirect_valid) begin
        exp_on = (redirect_pc[1:0] == 2'b00);
        exp_pc = redirect_pc;
      end
    end
    chk("sb_progress", 32'(npop > 500), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
